rvx_gpio_irq: RTL and testbench

Parametrised GPIO peripheral with per-pin output enable, atomic set/clear, and a synchronised, debounced input path. Adds per-pin rising/falling-edge interrupt detection with write-1-to-clear pending bits and a single level interrupt output. Sits on the peripheral register bus beside the other rvx peripherals, and its irq line goes to the interrupt controller.

---
 rtl/rvx_gpio_irq_pkg.sv | 32 +++
 rtl/rvx_gpio_irq_if.sv | 38 +++
 rtl/rvx_gpio_input_filter.sv | 78 +++++++
 rtl/rvx_gpio_irq.sv | 140 ++++++++++++++
 tb/tb_rvx_gpio_irq.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvx_gpio_irq_pkg.sv
// Shared definitions for the rvx GPIO peripheral: register map and
// write byte-enable decoding.
package rvx_gpio_irq_pkg;

  // Byte address on the peripheral register bus.
  typedef logic [4:0] rvx_gpio_addr_t;

  // Register map (word-aligned byte addresses).
  localparam rvx_gpio_addr_t RVX_GPIO_READ_REG_ADDR          = 5'h00;
  localparam rvx_gpio_addr_t RVX_GPIO_OUTPUT_ENABLE_REG_ADDR = 5'h04;
  localparam rvx_gpio_addr_t RVX_GPIO_OUTPUT_REG_ADDR        = 5'h08;
  localparam rvx_gpio_addr_t RVX_GPIO_CLEAR_REG_ADDR         = 5'h0C;
  localparam rvx_gpio_addr_t RVX_GPIO_SET_REG_ADDR           = 5'h10;
  localparam rvx_gpio_addr_t RVX_GPIO_RISE_EN_REG_ADDR       = 5'h14;
  localparam rvx_gpio_addr_t RVX_GPIO_FALL_EN_REG_ADDR       = 5'h18;
  localparam rvx_gpio_addr_t RVX_GPIO_PENDING_REG_ADDR       = 5'h1C;

  // Width of the shared debounce tick counter (divider up to 65535).
  localparam int RVX_GPIO_TICK_CNT_W = 16;

  // Only full-word, low-half and low-byte writes are honoured; any other
  // byte-enable pattern yields an all-zero mask so the write has no effect.
  function automatic logic [31:0] rvx_gpio_strobe_mask(input logic [3:0] strobe);
    case (strobe)
      4'b1111: return 32'hFFFF_FFFF;
      4'b0011: return 32'h0000_FFFF;
      4'b0001: return 32'h0000_00FF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/rvx_gpio_irq_if.sv
// Peripheral register bus as seen by the rvx GPIO block.
interface rvx_gpio_irq_if;
  import rvx_gpio_irq_pkg::*;

  rvx_gpio_addr_t rw_address;
  logic [31:0]    read_data;
  logic           read_request;
  logic           read_response;
  logic [31:0]    write_data;
  logic [3:0]     write_strobe;
  logic           write_request;
  logic           write_response;

  // Bus host side.
  modport master (
    output rw_address,
    output read_request,
    output write_data,
    output write_strobe,
    output write_request,
    input  read_data,
    input  read_response,
    input  write_response
  );

  // Peripheral side.
  modport slave (
    input  rw_address,
    input  read_request,
    input  write_data,
    input  write_strobe,
    input  write_request,
    output read_data,
    output read_response,
    output write_response
  );

endinterface

// File: rtl/rvx_gpio_input_filter.sv
// Input conditioning for the GPIO pins: a multi-stage synchroniser per pin
// followed by an optional tick-sampled stability (debounce) filter.
module rvx_gpio_input_filter
  import rvx_gpio_irq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] filt_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;

  // Shift the asynchronous pins through the synchroniser chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins_i};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_DIV == 0) begin : g_bypass
      assign filt_o = sync;
    end else begin : g_debounce
      localparam logic [RVX_GPIO_TICK_CNT_W-1:0] RELOAD =
        RVX_GPIO_TICK_CNT_W'(DEBOUNCE_DIV - 1);

      logic [RVX_GPIO_TICK_CNT_W-1:0] cnt_q, cnt_d;
      logic                           tick;
      logic [WIDTH-1:0]               sample_q, sample_d;
      logic [WIDTH-1:0]               filt_q, filt_d;
      logic [WIDTH-1:0]               stable;

      // A pin is accepted only when it matches the sample taken on the
      // previous tick, so any level must survive two consecutive ticks.
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
        assign stable[gi] = ~(sync[gi] ^ sample_q[gi]);
      end

      // Tick generation and per-pin sample/accept decision.
      always_comb begin
        tick     = (cnt_q == '0);
        cnt_d    = tick ? RELOAD : cnt_q - 1'b1;
        sample_d = sample_q;
        filt_d   = filt_q;
        if (tick) begin
          sample_d = sync;
          filt_d   = (filt_q & ~stable) | (sync & stable);
        end
      end

      // Filter state registers.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          cnt_q    <= '0;
          sample_q <= '0;
          filt_q   <= '0;
        end else begin
          cnt_q    <= cnt_d;
          sample_q <= sample_d;
          filt_q   <= filt_d;
        end
      end

      assign filt_o = filt_q;
    end
  endgenerate

endmodule

// File: rtl/rvx_gpio_irq.sv
// rvx GPIO peripheral: output enable/value registers with atomic set and
// clear, conditioned input readback, per-pin edge interrupts with
// write-1-to-clear pending bits and one level interrupt line.
module rvx_gpio_irq
  import rvx_gpio_irq_pkg::*;
#(
  parameter int GPIO_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  rvx_gpio_irq_if.slave         bus,
  input  logic [GPIO_WIDTH-1:0] gpio_input,
  output logic [GPIO_WIDTH-1:0] gpio_output_enable,
  output logic [GPIO_WIDTH-1:0] gpio_output,
  output logic                  irq
);

  localparam int W = GPIO_WIDTH;

  logic [W-1:0]  oe_q, oe_d;
  logic [W-1:0]  out_q, out_d;
  logic [W-1:0]  rise_en_q, rise_en_d;
  logic [W-1:0]  fall_en_q, fall_en_d;
  logic [W-1:0]  pend_q, pend_d;
  logic [W-1:0]  pend_clr;
  logic [W-1:0]  filt;
  logic [W-1:0]  filt_dly_q;
  logic [W-1:0]  edge_set;
  logic          irq_q;
  logic          read_response_q;
  logic          write_response_q;
  logic [31:0]   read_data_q, read_data_d;
  logic [W-1:0]  rd_val;
  logic [31:0]   wmask;
  logic [31:0]   wdata_m;
  logic [W-1:0]  wm;
  logic [W-1:0]  wd;
  logic          unused_wbits;

  rvx_gpio_input_filter #(
    .WIDTH        (W),
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_DIV (DEBOUNCE_DIV)
  ) u_filter (
    .clock  (clock),
    .reset  (reset),
    .pins_i (gpio_input),
    .filt_o (filt)
  );

  // Per-pin edge detection on the conditioned input; runs whatever the
  // output enable says, so looped-back driven pins can interrupt too.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_edge
      assign edge_set[gi] = (filt[gi] & ~filt_dly_q[gi] & rise_en_q[gi]) |
                            (~filt[gi] & filt_dly_q[gi] & fall_en_q[gi]);
    end
  endgenerate

  // Bits above the pin count never reach a register.
  assign unused_wbits = &{1'b0, wmask, wdata_m};

  // Register writes and pending update; a new edge beats a same-cycle clear.
  always_comb begin
    wmask     = rvx_gpio_strobe_mask(bus.write_strobe);
    wdata_m   = bus.write_data & wmask;
    wm        = wmask[W-1:0];
    wd        = wdata_m[W-1:0];
    oe_d      = oe_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;
    if (bus.write_request) begin
      case (bus.rw_address)
        RVX_GPIO_OUTPUT_ENABLE_REG_ADDR: oe_d      = (oe_q & ~wm) | wd;
        RVX_GPIO_OUTPUT_REG_ADDR:        out_d     = (out_q & ~wm) | wd;
        RVX_GPIO_CLEAR_REG_ADDR:         out_d     = out_q & ~wd;
        RVX_GPIO_SET_REG_ADDR:           out_d     = out_q | wd;
        RVX_GPIO_RISE_EN_REG_ADDR:       rise_en_d = (rise_en_q & ~wm) | wd;
        RVX_GPIO_FALL_EN_REG_ADDR:       fall_en_d = (fall_en_q & ~wm) | wd;
        RVX_GPIO_PENDING_REG_ADDR:       pend_clr  = wd;
        default: ;
      endcase
    end
    pend_d = (pend_q & ~pend_clr) | edge_set;
  end

  // Read multiplexer; write-only and unmapped addresses return zero.
  always_comb begin
    rd_val = '0;
    case (bus.rw_address)
      RVX_GPIO_READ_REG_ADDR:          rd_val = (oe_q & out_q) | (~oe_q & filt);
      RVX_GPIO_OUTPUT_ENABLE_REG_ADDR: rd_val = oe_q;
      RVX_GPIO_OUTPUT_REG_ADDR:        rd_val = out_q;
      RVX_GPIO_RISE_EN_REG_ADDR:       rd_val = rise_en_q;
      RVX_GPIO_FALL_EN_REG_ADDR:       rd_val = fall_en_q;
      RVX_GPIO_PENDING_REG_ADDR:       rd_val = pend_q;
      default:                         rd_val = '0;
    endcase
    read_data_d = bus.read_request ? 32'(rd_val) : read_data_q;
  end

  // State, response and interrupt registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oe_q             <= '0;
      out_q            <= '0;
      rise_en_q        <= '0;
      fall_en_q        <= '0;
      pend_q           <= '0;
      filt_dly_q       <= '0;
      irq_q            <= 1'b0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      read_data_q      <= '0;
    end else begin
      oe_q             <= oe_d;
      out_q            <= out_d;
      rise_en_q        <= rise_en_d;
      fall_en_q        <= fall_en_d;
      pend_q           <= pend_d;
      filt_dly_q       <= filt;
      irq_q            <= |pend_q;
      read_response_q  <= bus.read_request;
      write_response_q <= bus.write_request;
      read_data_q      <= read_data_d;
    end
  end

  assign bus.read_data       = read_data_q;
  assign bus.read_response   = read_response_q;
  assign bus.write_response  = write_response_q;
  assign gpio_output_enable  = oe_q;
  assign gpio_output         = out_q;
  assign irq                 = irq_q;

endmodule

// File: tb/tb_rvx_gpio_irq.sv
// Self-checking bench for rvx_gpio_irq. Four instances are exercised:
// d0 = 8 pins no debounce, d1 = 8 pins DEBOUNCE_DIV=10, d2 = 32 pins,
// d3 = 1 pin. A register-level model tracks every instance.
module tb_rvx_gpio_irq;
  import rvx_gpio_irq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [4:0]  addr_v  [4];
  logic [31:0] wdata_v [4];
  logic [3:0]  strb_v  [4];
  logic        rreq_v  [4];
  logic        wreq_v  [4];
  logic [31:0] gin_v   [4];

  wire [31:0] rdata_w [4];
  wire [31:0] gout_w  [4];
  wire [31:0] goe_w   [4];
  wire        rresp_w [4];
  wire        wresp_w [4];
  wire        irq_w   [4];

  // Model state per instance.
  logic [31:0] msk_m [4];
  logic [31:0] oe_m  [4];
  logic [31:0] out_m [4];
  logic [31:0] re_m  [4];
  logic [31:0] fe_m  [4];
  logic [31:0] pend_m[4];
  logic [31:0] in_m  [4];
  int          settle_m [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int W   = (gi == 2) ? 32 : ((gi == 3) ? 1 : 8);
      localparam int DIV = (gi == 1) ? 10 : 0;
      wire [W-1:0] go;
      wire [W-1:0] goe;
      wire         irq_s;
      rvx_gpio_irq_if bus_if ();
      assign bus_if.rw_address    = addr_v[gi];
      assign bus_if.write_data    = wdata_v[gi];
      assign bus_if.write_strobe  = strb_v[gi];
      assign bus_if.read_request  = rreq_v[gi];
      assign bus_if.write_request = wreq_v[gi];
      assign rdata_w[gi] = bus_if.read_data;
      assign rresp_w[gi] = bus_if.read_response;
      assign wresp_w[gi] = bus_if.write_response;
      rvx_gpio_irq #(
        .GPIO_WIDTH   (W),
        .SYNC_STAGES  (2),
        .DEBOUNCE_DIV (DIV)
      ) u_dut (
        .clock              (clk),
        .reset              (rst),
        .bus                (bus_if),
        .gpio_input         (gin_v[gi][W-1:0]),
        .gpio_output_enable (goe),
        .gpio_output        (go),
        .irq                (irq_s)
      );
      assign gout_w[gi] = 32'(go);
      assign goe_w[gi]  = 32'(goe);
      assign irq_w[gi]  = irq_s;
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] st);
    if (st == 4'hF) return 32'hFFFF_FFFF;
    if (st == 4'h3) return 32'h0000_FFFF;
    if (st == 4'h1) return 32'h0000_00FF;
    return 32'h0;
  endfunction

  function automatic logic [3:0] pick_strobe(input int k);
    case (k)
      0: return 4'hF;
      1: return 4'h3;
      2: return 4'h1;
      3: return 4'h4;
      4: return 4'hC;
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      oe_m[d] = 0; out_m[d] = 0; re_m[d] = 0; fe_m[d] = 0; pend_m[d] = 0;
    end
  endtask

  task automatic model_write(input int d, input logic [4:0] a, input logic [31:0] wd,
                             input logic [3:0] st);
    logic [31:0] m;
    logic [31:0] v;
    m = bmask(st) & msk_m[d];
    v = wd & m;
    case (a)
      RVX_GPIO_OUTPUT_ENABLE_REG_ADDR: oe_m[d]   = (oe_m[d] & ~m) | v;
      RVX_GPIO_OUTPUT_REG_ADDR:        out_m[d]  = (out_m[d] & ~m) | v;
      RVX_GPIO_CLEAR_REG_ADDR:         out_m[d]  = out_m[d] & ~v;
      RVX_GPIO_SET_REG_ADDR:           out_m[d]  = out_m[d] | v;
      RVX_GPIO_RISE_EN_REG_ADDR:       re_m[d]   = (re_m[d] & ~m) | v;
      RVX_GPIO_FALL_EN_REG_ADDR:       fe_m[d]   = (fe_m[d] & ~m) | v;
      RVX_GPIO_PENDING_REG_ADDR:       pend_m[d] = pend_m[d] & ~v;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [4:0] a);
    case (a)
      RVX_GPIO_READ_REG_ADDR:
        return ((oe_m[d] & out_m[d]) | (~oe_m[d] & in_m[d])) & msk_m[d];
      RVX_GPIO_OUTPUT_ENABLE_REG_ADDR: return oe_m[d];
      RVX_GPIO_OUTPUT_REG_ADDR:        return out_m[d];
      RVX_GPIO_RISE_EN_REG_ADDR:       return re_m[d];
      RVX_GPIO_FALL_EN_REG_ADDR:       return fe_m[d];
      RVX_GPIO_PENDING_REG_ADDR:       return pend_m[d];
      default:                         return 32'h0;
    endcase
  endfunction

  // One write transaction; response must appear exactly one cycle later.
  task automatic bus_write(input int d, input logic [4:0] a, input logic [31:0] wd,
                           input logic [3:0] st);
    $display("[TB] d%0d WR addr=%02h data=%08h strobe=%b", d, a, wd, st);
    addr_v[d] = a; wdata_v[d] = wd; strb_v[d] = st; wreq_v[d] = 1'b1;
    check("wr_resp_before", 32'(wresp_w[d]), 32'h0);
    @(posedge clk); #1;
    check("wr_resp_after", 32'(wresp_w[d]), 32'h1);
    wreq_v[d] = 1'b0;
    model_write(d, a, wd, st);
    cycles(1);
  endtask

  task automatic bus_read(input int d, input logic [4:0] a, output logic [31:0] data);
    addr_v[d] = a; rreq_v[d] = 1'b1;
    check("rd_resp_before", 32'(rresp_w[d]), 32'h0);
    @(posedge clk); #1;
    check("rd_resp_after", 32'(rresp_w[d]), 32'h1);
    data = rdata_w[d];
    rreq_v[d] = 1'b0;
    addr_v[d] = 5'h04;
    cycles(1);
    check("rd_data_hold", rdata_w[d], data);
    $display("[TB] d%0d RD addr=%02h data=%08h", d, a, data);
  endtask

  task automatic read_check(input int d, input logic [4:0] a, input string tag);
    logic [31:0] data;
    bus_read(d, a, data);
    check(tag, data, model_read(d, a));
  endtask

  task automatic check_pins(input int d);
    check("gpio_oe", goe_w[d], oe_m[d]);
    check("gpio_out", gout_w[d], out_m[d]);
    check("irq_level", 32'(irq_w[d]), 32'(pend_m[d] != 0));
  endtask

  // Apply a new settled input level and derive pending from the edges.
  task automatic set_in(input int d, input logic [31:0] v);
    logic [31:0] nv;
    nv = v & msk_m[d];
    $display("[TB] d%0d PIN %08h -> %08h", d, in_m[d], nv);
    gin_v[d] = v;
    cycles(settle_m[d]);
    pend_m[d] = pend_m[d] | (((nv & ~in_m[d]) & re_m[d]) | ((in_m[d] & ~nv) & fe_m[d]));
    in_m[d] = nv;
  endtask

  initial begin
    logic [31:0] rd;
    for (int d = 0; d < 4; d++) begin
      addr_v[d] = 0; wdata_v[d] = 0; strb_v[d] = 0; rreq_v[d] = 0; wreq_v[d] = 0;
      gin_v[d] = 0; in_m[d] = 0;
    end
    msk_m[0] = 32'hFF; msk_m[1] = 32'hFF; msk_m[2] = 32'hFFFF_FFFF; msk_m[3] = 32'h1;
    settle_m[0] = 6; settle_m[1] = 30; settle_m[2] = 6; settle_m[3] = 6;
    model_reset();

    // Power-on reset.
    #1 rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(1);

    // Reset in the middle of a write: no response, everything back to zero.
    bus_write(0, RVX_GPIO_OUTPUT_ENABLE_REG_ADDR, 32'hFF, 4'hF);
    addr_v[0] = RVX_GPIO_OUTPUT_REG_ADDR; wdata_v[0] = 32'h55; strb_v[0] = 4'hF;
    wreq_v[0] = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wr_resp", 32'(wresp_w[0]), 32'h0);
    check("rst_irq", 32'(irq_w[0]), 32'h0);
    wreq_v[0] = 1'b0;
    cycles(1);
    rst = 1'b0;
    model_reset();
    cycles(1);
    for (int d = 0; d < 4; d++) begin
      for (int r = 0; r < 8; r++) read_check(d, 5'(r * 4), "reset_readback");
      check_pins(d);
    end

    // Output register path.
    bus_write(0, RVX_GPIO_OUTPUT_ENABLE_REG_ADDR, 32'hFF, 4'hF);
    bus_write(0, RVX_GPIO_OUTPUT_REG_ADDR, 32'hA5, 4'hF);
    bus_write(0, RVX_GPIO_SET_REG_ADDR, 32'h0A, 4'hF);
    bus_write(0, RVX_GPIO_CLEAR_REG_ADDR, 32'h81, 4'hF);
    check("out_after_set_clear", gout_w[0], 32'h2E);
    check_pins(0);
    read_check(0, RVX_GPIO_READ_REG_ADDR, "read_driven");
    bus_write(0, RVX_GPIO_OUTPUT_REG_ADDR, 32'hFF, 4'b0100);
    read_check(0, RVX_GPIO_OUTPUT_REG_ADDR, "out_bad_strobe");
    read_check(0, RVX_GPIO_SET_REG_ADDR, "set_reads_zero");
    bus_write(0, RVX_GPIO_OUTPUT_ENABLE_REG_ADDR, 32'h00, 4'hF);

    // Rising edge, no debounce: pending at 3 cycles, irq at 4.
    bus_write(0, RVX_GPIO_RISE_EN_REG_ADDR, 32'h01, 4'hF);
    gin_v[0] = 32'h01;
    cycles(3);
    check("rise_irq_cyc3", 32'(irq_w[0]), 32'h0);
    cycles(1);
    check("rise_irq_cyc4", 32'(irq_w[0]), 32'h1);
    in_m[0] = 32'h01;
    pend_m[0] = pend_m[0] | 32'h01;
    read_check(0, RVX_GPIO_PENDING_REG_ADDR, "rise_pending");
    read_check(0, RVX_GPIO_READ_REG_ADDR, "rise_read");
    bus_write(0, RVX_GPIO_PENDING_REG_ADDR, 32'h01, 4'hF);
    check_pins(0);
    read_check(0, RVX_GPIO_PENDING_REG_ADDR, "w1c_pending");

    // Falling edge colliding with a W1C of the same bit: set wins.
    bus_write(0, RVX_GPIO_FALL_EN_REG_ADDR, 32'h04, 4'hF);
    set_in(0, 32'h05);
    read_check(0, RVX_GPIO_PENDING_REG_ADDR, "fall_pre");
    gin_v[0] = 32'h01;
    cycles(2);
    bus_write(0, RVX_GPIO_PENDING_REG_ADDR, 32'h04, 4'hF);
    in_m[0] = 32'h01;
    pend_m[0] = pend_m[0] | 32'h04;
    read_check(0, RVX_GPIO_PENDING_REG_ADDR, "collide_pending");
    check_pins(0);
    bus_write(0, RVX_GPIO_FALL_EN_REG_ADDR, 32'h00, 4'hF);
    read_check(0, RVX_GPIO_PENDING_REG_ADDR, "en_clear_keeps_pending");
    bus_write(0, RVX_GPIO_PENDING_REG_ADDR, 32'h04, 4'hF);
    check_pins(0);

    // Debounce: short glitch rejected, stable level accepted.
    bus_write(1, RVX_GPIO_RISE_EN_REG_ADDR, 32'h02, 4'hF);
    gin_v[1] = 32'h02;
    cycles(5);
    gin_v[1] = 32'h00;
    cycles(30);
    read_check(1, RVX_GPIO_READ_REG_ADDR, "glitch_read");
    read_check(1, RVX_GPIO_PENDING_REG_ADDR, "glitch_pending");
    set_in(1, 32'h02);
    read_check(1, RVX_GPIO_READ_REG_ADDR, "stable_read");
    read_check(1, RVX_GPIO_PENDING_REG_ADDR, "stable_pending");
    check_pins(1);

    // Width sweep on 32-pin and 1-pin instances.
    for (int d = 2; d < 4; d++) begin
      for (int i = 0; i < 32; i++) begin
        bus_write(d, RVX_GPIO_OUTPUT_REG_ADDR, 32'(1) << i, 4'hF);
        read_check(d, RVX_GPIO_OUTPUT_REG_ADDR, "walk_out");
        bus_write(d, RVX_GPIO_RISE_EN_REG_ADDR, 32'(1) << i, 4'hF);
        read_check(d, RVX_GPIO_RISE_EN_REG_ADDR, "walk_rise_en");
      end
      bus_write(d, RVX_GPIO_RISE_EN_REG_ADDR, 32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 32; i++) begin
        if (msk_m[d][i]) begin
          set_in(d, 32'(1) << i);
          read_check(d, RVX_GPIO_PENDING_REG_ADDR, "walk_pending");
          bus_write(d, RVX_GPIO_PENDING_REG_ADDR, 32'(1) << i, 4'hF);
        end
      end
      set_in(d, 32'h0);
      check_pins(d);
    end

    // Randomised register and pin traffic against the model.
    for (int n = 0; n < 80; n++) begin
      int d;
      int op;
      d  = $urandom_range(0, 3);
      op = $urandom_range(0, 2);
      if (op < 2) begin
        bus_write(d, 5'($urandom_range(0, 7) * 4), $urandom,
                  pick_strobe($urandom_range(0, 5)));
      end else begin
        set_in(d, $urandom);
      end
      read_check(d, 5'($urandom_range(0, 7) * 4), "random_read");
      check_pins(d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
